i2s_stream_tx: RTL and testbench
================================

Name: i2s_stream_tx

Overview:
Parametrised stereo sample-to-I2S transmitter. It replaces the fixed 16-to-24-bit sample hold and serializer between the FM synth sample output and the external DAC. Sample pairs arrive through a valid/ready handshake and are scaled with saturation. They are buffered in a DEPTH-entry FIFO and serialized as I2S or left-justified frames, with BCK and LRCK derived from clk. Underflow is flagged, and the last frame is repeated so the output stays free of clicks.

Parameters:
IN_W, 16, input sample width (signed two's complement)
OUT_W, 24, bits per output slot; must be at least IN_W
DEPTH, 4, FIFO depth in stereo pairs; power of 2, at least 2
BCK_HALF, 2, clk cycles per BCK half-period; at least 1

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-high
enable  in  1  1 = run the serial interface; 0 = idle the outputs (FIFO still accepts data)
mode  in  1  0 = I2S (LRCK leads MSB by one BCK), 1 = left-justified
gain  in  4  left-shift amount applied on write, 0..15
in_valid  in  1  sample pair present
in_ready  out  1  FIFO can accept a pair
in_left  in  IN_W  left sample, signed
in_right  in  IN_W  right sample, signed
i2s_bck  out  1  bit clock
i2s_lrck  out  1  word select; 0 = left slot, 1 = right slot
i2s_data  out  1  serial data, MSB first
underflow  out  1  one-clk pulse when a frame load finds the FIFO empty
fifo_level  out  $clog2(DEPTH+1)  pairs currently stored

Behaviour:
- Interface: clock is clk; reset rst is asynchronous and active-high.
- Reset values: in_ready=1, i2s_bck=0, i2s_lrck=0, i2s_data=0, underflow=0, fifo_level=0. The FIFO, the last-frame register and all counters clear to 0.
- Reset mid-frame aborts the frame immediately. No partial state survives.
- Write handshake:
  - A push occurs when in_valid && in_ready. in_ready = (fifo_level != DEPTH).
  - When full, no push occurs, even if a pop happens in the same cycle.
  - gain is sampled at push.
- Scaling: each channel is sign-extended to OUT_W, then shifted left by gain.
  - If the true result exceeds the signed OUT_W range, it saturates to 2^(OUT_W-1)-1 or -2^(OUT_W-1).
  - The scaled value is stored in the FIFO.
- fifo_level changes by +1 on push, -1 on pop, and is unchanged on simultaneous push and pop. Pointers wrap modulo DEPTH.
- Clock divider:
  - Active only while enable=1. A counter runs 0..BCK_HALF-1; at BCK_HALF-1 it wraps and i2s_bck toggles.
  - A "fall tick" is the clk on which bck toggles 1 to 0.
- Bit counter bitcnt (0..2*OUT_W-1): advances on each fall tick, wrapping from 2*OUT_W-1 to 0.
- Load event:
  - Occurs on the fall tick where bitcnt wraps to 0, and on the first clk with enable=1 after reset or after enable=0.
  - At a load event: if the FIFO is non-empty, pop one pair into the shift register {L,R} and also into the last-frame register.
  - If the FIFO is empty, reload from the last-frame register and pulse underflow for 1 clk.
  - A push in the same clk as a load that finds the FIFO empty is not bypassed: underflow fires and the pushed pair waits for the next frame.
- mode is sampled at each load event and held for the whole frame.
- Shift: the shift register shifts left by 1 on every fall tick except a load tick. i2s_data = shift register MSB (registered).
- LRCK:
  - Left-justified: lrck = (bitcnt >= OUT_W).
  - I2S: lrck = (((bitcnt+1) mod 2*OUT_W) >= OUT_W). LRCK therefore transitions one BCK before each channel MSB.
- Data timing: data and LRCK change only on falling BCK. The receiver samples on rising BCK.
- enable=0: the divider and bitcnt reset to 0 and bck, lrck, data are forced to 0 within 1 clk. The FIFO contents are kept.
- Frame rate = f_clk / (4*BCK_HALF*OUT_W).

Test Plan:
- Reset, then defaults, enable=0: all outputs 0; in_ready=1; push 4 pairs, so fifo_level=4 and in_ready=0; a 5th in_valid is refused and the level stays 4.
- Scaling, IN_W=16, OUT_W=24, mode=1: gain=0 with left=16'h8001 gives left slot 24'hFF8001. gain=2 with right=16'h1234 gives 24'h0048D0. Check bit-by-bit on rising BCK, MSB at bitcnt 0, with lrck=0 for the left slot.
- Saturation: gain=9 with left=16'h4000 gives 24'h7FFFFF. gain=9 with right=16'hC000 gives 24'h800000. gain=15 with left=16'hFFFF (-1) gives 24'hFF8000 (no saturation).
- I2S framing, mode=0: LRCK falls one BCK before the left MSB and rises one BCK before the right MSB. The frame is 48 BCKs, and BCK period = 4 clk with BCK_HALF=2.
- Underflow: push 1 pair (L=16'h0101, R=16'h0202) and run 2 frames. The second frame repeats 0101/0202, underflow pulses exactly once, and fifo_level=0.
- Mid-frame disruption: deassert enable at bitcnt 10, so outputs are 0 within 1 clk. Re-enable, and the next pair starts cleanly at bitcnt 0. Assert rst mid-frame, and all outputs and fifo_level are 0 asynchronously.

Source files
------------

// File: rtl/i2s_stream_tx.sv
// +--------------------------------------------------------------------------+
// | Module : i2s_stream_tx                                                   |
// | Stereo sample FIFO with gain/saturation feeding an I2S / LJ serializer.  |
// | Rev    : 1.0                                                             |
// +--------------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module i2s_stream_tx #(
  parameter int IN_W     = 16,
  parameter int OUT_W    = 24,
  parameter int DEPTH    = 4,
  parameter int BCK_HALF = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       enable,
  input  logic                       mode,
  input  logic [3:0]                 gain,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [IN_W-1:0]            in_left,
  input  logic [IN_W-1:0]            in_right,
  output logic                       i2s_bck,
  output logic                       i2s_lrck,
  output logic                       i2s_data,
  output logic                       underflow,
  output logic [$clog2(DEPTH+1)-1:0] fifo_level
);

  localparam int c_FRAME = 2 * OUT_W;
  localparam int c_LVL_W = $clog2(DEPTH + 1);
  localparam int c_PTR_W = $clog2(DEPTH);
  localparam int c_BIT_W = $clog2(c_FRAME);
  localparam int c_DIV_W = (BCK_HALF > 1) ? $clog2(BCK_HALF) : 1;
  localparam int c_EXT_W = OUT_W + 16;

  // Widened enough that a 15-bit shift can never lose the true magnitude.
  function automatic logic [OUT_W-1:0] f_scale(input logic [IN_W-1:0] s, input logic [3:0] g);
    logic signed [c_EXT_W-1:0] v;
    logic signed [c_EXT_W-1:0] hi;
    logic signed [c_EXT_W-1:0] lo;
    v  = signed'({{(c_EXT_W-IN_W){s[IN_W-1]}}, s});
    v  = v <<< g;
    hi = signed'({{(c_EXT_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}});
    lo = ~hi;
    if (v > hi) return hi[OUT_W-1:0];
    if (v < lo) return lo[OUT_W-1:0];
    return v[OUT_W-1:0];
  endfunction

  function automatic logic f_lrck(input logic [c_BIT_W-1:0] b, input logic lj);
    if (lj) return (int'(b) >= OUT_W);
    return (b != c_BIT_W'(c_FRAME-1)) && ((int'(b) + 1) >= OUT_W);
  endfunction

  logic [OUT_W-1:0]   r_mem_l [DEPTH];
  logic [OUT_W-1:0]   r_mem_r [DEPTH];
  logic [c_PTR_W-1:0] r_wr_ptr;
  logic [c_PTR_W-1:0] r_rd_ptr;
  logic [c_LVL_W-1:0] r_level;
  logic [c_FRAME-1:0] r_last;
  logic [c_FRAME-1:0] r_shift;
  logic [c_DIV_W-1:0] r_div;
  logic [c_BIT_W-1:0] r_bitcnt;
  logic               r_bck;
  logic               r_lrck;
  logic               r_mode;
  logic               r_active;
  logic               r_underflow;

  logic               w_push;
  logic               w_tick;
  logic               w_fall;
  logic               w_wrap;
  logic               w_load;
  logic               w_pop;
  logic [c_BIT_W-1:0] w_bit_nxt;
  logic [c_FRAME-1:0] w_head;

  assign in_ready   = (r_level != c_LVL_W'(DEPTH));
  assign w_push     = in_valid && in_ready;
  assign w_tick     = enable && (r_div == c_DIV_W'(BCK_HALF-1));
  assign w_fall     = w_tick && r_bck;
  assign w_wrap     = (r_bitcnt == c_BIT_W'(c_FRAME-1));
  // A load also happens on the first enabled clk so a restart never emits stale bits.
  assign w_load     = enable && (!r_active || (w_fall && w_wrap));
  assign w_pop      = w_load && (r_level != '0);
  assign w_bit_nxt  = w_wrap ? '0 : r_bitcnt + 1'b1;
  assign w_head     = {r_mem_l[r_rd_ptr], r_mem_r[r_rd_ptr]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem_l[i] <= '0;
        r_mem_r[i] <= '0;
      end
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) begin
        r_mem_l[r_wr_ptr] <= f_scale(in_left, gain);
        r_mem_r[r_wr_ptr] <= f_scale(in_right, gain);
        r_wr_ptr          <= r_wr_ptr + 1'b1;
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_push && !w_pop)      r_level <= r_level + 1'b1;
      else if (!w_push && w_pop) r_level <= r_level - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_div       <= '0;
      r_bck       <= 1'b0;
      r_bitcnt    <= '0;
      r_lrck      <= 1'b0;
      r_shift     <= '0;
      r_last      <= '0;
      r_mode      <= 1'b0;
      r_active    <= 1'b0;
      r_underflow <= 1'b0;
    end else if (!enable) begin
      r_div       <= '0;
      r_bck       <= 1'b0;
      r_bitcnt    <= '0;
      r_lrck      <= 1'b0;
      r_shift     <= '0;
      r_active    <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_active    <= 1'b1;
      r_underflow <= w_load && (r_level == '0);
      if (w_tick) begin
        r_div <= '0;
        r_bck <= ~r_bck;
      end else begin
        r_div <= r_div + 1'b1;
      end
      if (w_load) begin
        r_shift  <= w_pop ? w_head : r_last;
        r_mode   <= mode;
        r_bitcnt <= '0;
        r_lrck   <= f_lrck('0, mode);
        if (w_pop) r_last <= w_head;
      end else if (w_fall) begin
        r_shift  <= r_shift << 1;
        r_bitcnt <= w_bit_nxt;
        r_lrck   <= f_lrck(w_bit_nxt, r_mode);
      end
    end
  end

  assign i2s_bck    = r_bck;
  assign i2s_lrck   = r_lrck;
  assign i2s_data   = r_shift[c_FRAME-1];
  assign underflow  = r_underflow;
  assign fifo_level = r_level;

endmodule

`default_nettype wire

// File: tb/tb_i2s_stream_tx.sv
// Bench for i2s_stream_tx: frame-level model checked on every rising BCK plus literal frames.
`timescale 1ns/1ps
`default_nettype none

module tb_i2s_stream_tx;
  localparam int IN_W = 16, OUT_W = 24, DEPTH = 4, BCK_HALF = 2, FRAME = 48;

  logic        clk = 1'b0;
  logic        rst, enable, mode, in_valid;
  logic [3:0]  gain;
  logic [15:0] in_left, in_right;
  logic        in_ready, i2s_bck, i2s_lrck, i2s_data, underflow;
  logic [2:0]  fifo_level;

  always #5 clk = ~clk;

  i2s_stream_tx #(.IN_W(IN_W), .OUT_W(OUT_W), .DEPTH(DEPTH), .BCK_HALF(BCK_HALF)) dut (
    .clk(clk), .rst(rst), .enable(enable), .mode(mode), .gain(gain),
    .in_valid(in_valid), .in_ready(in_ready), .in_left(in_left), .in_right(in_right),
    .i2s_bck(i2s_bck), .i2s_lrck(i2s_lrck), .i2s_data(i2s_data),
    .underflow(underflow), .fifo_level(fifo_level)
  );

  int n_cmp = 0, n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Mathematical scaling: value * 2^gain, clamped to the signed 24-bit range.
  function automatic logic [23:0] model_scale(input logic [15:0] s, input int g);
    longint v;
    v = longint'($signed(s)) * (longint'(1) << g);
    if (v > 64'sd8388607) v = 64'sd8388607;
    else if (v < -64'sd8388608) v = -64'sd8388608;
    return v[23:0];
  endfunction

  logic [47:0] mq[$];
  logic [47:0] rx_q[$];
  logic [47:0] rx_lrq[$];
  logic [47:0] m_last, m_cur, rx_word, rx_lr;
  logic        m_mode, prev_bck, en_q, have_rise;
  int          m_k, exp_uf, uf_cnt, since_rise;

  always @(posedge clk or posedge rst) begin
    if (rst) en_q <= 1'b0;
    else     en_q <= enable;
  end

  initial begin
    m_last = '0; m_cur = '0; rx_word = '0; rx_lr = '0; m_mode = 1'b0;
    prev_bck = 1'b0; have_rise = 1'b0; m_k = 0; exp_uf = 0; uf_cnt = 0; since_rise = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        mq.delete();
        m_last = '0; m_k = 0; have_rise = 1'b0; since_rise = 0; exp_uf = 0; uf_cnt = 0;
      end else begin
        if (underflow) uf_cnt++;
        if (!en_q) begin
          chk("idle_outputs", {i2s_bck, i2s_lrck, i2s_data}, 3'b000);
          m_k = 0; have_rise = 1'b0; since_rise = 0;
        end else begin
          since_rise++;
          if (i2s_bck && !prev_bck) begin
            if (have_rise) chk("bck_period", since_rise, 2 * BCK_HALF);
            have_rise = 1'b1; since_rise = 0;
            if (m_k == 0) begin
              if (mq.size() > 0) begin
                m_cur = mq.pop_front();
                m_last = m_cur;
              end else begin
                m_cur = m_last;
                exp_uf++;
              end
              m_mode = mode;
            end
            chk("data_bit", i2s_data, m_cur[47-m_k]);
            chk("lrck_bit", i2s_lrck, m_mode ? (m_k >= 24) : (((m_k + 1) % FRAME) >= 24));
            rx_word = {rx_word[46:0], i2s_data};
            rx_lr   = {rx_lr[46:0], i2s_lrck};
            if (m_k == FRAME - 1) begin
              rx_q.push_back(rx_word);
              rx_lrq.push_back(rx_lr);
            end
            m_k = (m_k + 1) % FRAME;
          end
        end
      end
      prev_bck = i2s_bck;
    end
  end

  task automatic push(input logic [15:0] l, input logic [15:0] r, input logic [3:0] g);
    @(negedge clk);
    in_left = l; in_right = r; gain = g; in_valid = 1'b1;
    chk("in_ready", in_ready, mq.size() < DEPTH);
    @(posedge clk);
    if (mq.size() < DEPTH) mq.push_back({model_scale(l, g), model_scale(r, g)});
    @(negedge clk);
    in_valid = 1'b0;
    chk("level_after_push", fifo_level, mq.size());
  endtask

  task automatic wait_frames(input int n, input int budget);
    int c;
    c = 0;
    while (rx_q.size() < n && c < budget) begin
      @(negedge clk);
      c++;
    end
    chk("frames_arrived", rx_q.size() >= n, 1'b1);
  endtask

  task automatic clear_rx();
    rx_q.delete(); rx_lrq.delete(); uf_cnt = 0; exp_uf = 0;
  endtask

  initial begin
    int c;
    rst = 1'b1; enable = 1'b0; mode = 1'b1; in_valid = 1'b0; gain = 4'd0;
    in_left = '0; in_right = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_outputs", {i2s_bck, i2s_lrck, i2s_data, underflow}, 4'b0000);
    chk("rst_level", fifo_level, 3'd0);

    // Fill the FIFO, then one refused push.
    push(16'h8001, 16'h0000, 4'd0);
    push(16'h0000, 16'h1234, 4'd2);
    push(16'h4000, 16'hC000, 4'd9);
    push(16'hFFFF, 16'h0001, 4'd15);
    push(16'h7777, 16'h7777, 4'd0);
    chk("full_level", fifo_level, 3'd4);
    chk("full_ready", in_ready, 1'b0);

    // Left-justified playback of the four scaled pairs.
    mode = 1'b1; enable = 1'b1;
    wait_frames(4, 1200);
    chk("lj_frame0", rx_q[0], {24'hFF8001, 24'h000000});
    chk("lj_frame1", rx_q[1], {24'h000000, 24'h0048D0});
    chk("lj_frame2", rx_q[2], {24'h7FFFFF, 24'h800000});
    chk("lj_frame3", rx_q[3], {24'hFF8000, 24'h008000});
    chk("lj_lrck", rx_lrq[0], 48'h0000_00FF_FFFF);
    repeat (40) @(negedge clk);
    enable = 1'b0;
    @(negedge clk);
    chk("lj_underflow_cnt", uf_cnt, 1);
    chk("lj_underflow_model", uf_cnt, exp_uf);
    chk("lj_level", fifo_level, 3'd0);

    // Underflow: one pair, two frames.
    clear_rx();
    push(16'h0101, 16'h0202, 4'd0);
    enable = 1'b1;
    wait_frames(2, 600);
    chk("uf_frame0", rx_q[0], {24'h000101, 24'h000202});
    chk("uf_frame1", rx_q[1], {24'h000101, 24'h000202});
    chk("uf_pulse_once", uf_cnt, 1);
    chk("uf_level", fifo_level, 3'd0);
    repeat (20) @(negedge clk);
    enable = 1'b0;
    @(negedge clk);
    chk("uf_model", uf_cnt, exp_uf);

    // I2S framing.
    clear_rx();
    push(16'h1234, 16'hABCD, 4'd0);
    push(16'h7FFF, 16'h8000, 4'd1);
    mode = 1'b0; enable = 1'b1;
    wait_frames(2, 600);
    chk("i2s_frame0", rx_q[0], {24'h001234, 24'hFFABCD});
    chk("i2s_frame1", rx_q[1], {24'h00FFFE, 24'hFF0000});
    chk("i2s_lrck0", rx_lrq[0], 48'h0000_01FF_FFFE);
    chk("i2s_lrck1", rx_lrq[1], 48'h0000_01FF_FFFE);
    repeat (20) @(negedge clk);
    enable = 1'b0;
    @(negedge clk);

    // Enable dropped mid-frame, then a clean restart.
    clear_rx();
    mode = 1'b1;
    push(16'h5A5A, 16'hA5A5, 4'd0);
    push(16'h1357, 16'h2468, 4'd0);
    enable = 1'b1;
    c = 0;
    while (m_k != 11 && c < 300) begin
      @(negedge clk);
      c++;
    end
    chk("reach_bit10", m_k, 11);
    enable = 1'b0;
    @(posedge clk);
    #1;
    chk("dis_outputs", {i2s_bck, i2s_lrck, i2s_data}, 3'b000);
    chk("dis_level_kept", fifo_level, 3'd1);
    @(negedge clk);
    clear_rx();
    enable = 1'b1;
    wait_frames(1, 300);
    chk("restart_frame", rx_q[0], {24'h001357, 24'h002468});
    chk("restart_level", fifo_level, 3'd0);
    repeat (10) @(negedge clk);
    enable = 1'b0;

    // Asynchronous reset mid-frame.
    push(16'h1111, 16'h2222, 4'd0);
    push(16'h3333, 16'h4444, 4'd0);
    enable = 1'b1;
    repeat (100) @(negedge clk);
    chk("pre_rst_level", fifo_level, 3'd1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_level", fifo_level, 3'd0);
    chk("async_rst_outputs", {i2s_bck, i2s_lrck, i2s_data, underflow}, 4'b0000);
    chk("async_rst_ready", in_ready, 1'b1);
    enable = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
